// File: rtl/can_pkg.sv
// can_pkg: field widths and FSM state type shared by the CAN transmit blocks
package can_pkg;
  localparam int ID_LEN = 11;
  localparam int DLC_LEN = 4;
  localparam int HDR_LEN = 19;
  localparam int STUFF_RUN = 5;
  typedef enum logic [2:0] {s_idle, s_arm, s_hdr, s_stuff, s_finish} canHdrTx_t;
endpackage

// File: rtl/can_hdr_tx_if.sv
// can_hdr_tx_if: frame-controller bus of can_hdr_tx; CAN_HDR_TX_STUFF_ERR_EN adds injectStuffErr
interface can_hdr_tx_if;
  import can_pkg::*;
  logic enable;
  logic bitPulse;
  logic [ID_LEN-1:0] canId;
  logic rtr;
  logic [DLC_LEN-1:0] dlc;
  logic dOut;
  logic txActive;
  logic completeTx;
  logic [2:0] stuffCount;
  logic [4:0] bitCount;
`ifdef CAN_HDR_TX_STUFF_ERR_EN
  logic injectStuffErr;
  modport master(output enable, bitPulse, canId, rtr, dlc, injectStuffErr,
                 input dOut, txActive, completeTx, stuffCount, bitCount);
  modport slave(input enable, bitPulse, canId, rtr, dlc, injectStuffErr,
                output dOut, txActive, completeTx, stuffCount, bitCount);
`else
  modport master(output enable, bitPulse, canId, rtr, dlc,
                 input dOut, txActive, completeTx, stuffCount, bitCount);
  modport slave(input enable, bitPulse, canId, rtr, dlc,
                output dOut, txActive, completeTx, stuffCount, bitCount);
`endif
endinterface

// File: rtl/can_hdr_tx_stuff_gen.sv
// stuff_gen: tracks the run of equal transmitted bits and flags when bitIn would complete a stuffable run
module stuff_gen
  import can_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic load,
  input  logic step,
  input  logic bitIn,
  output logic lastBit,
  output logic stuffDue
);
  logic [2:0] runLen;
  assign stuffDue = bitIn == lastBit && runLen == 3'(STUFF_RUN - 1);
  always_ff @(posedge clk)
    if (!resetN) begin
      lastBit <= 1'b1;
      runLen <= '0;
    end else if (load || step) begin
      lastBit <= bitIn;
      runLen <= (step && bitIn == lastBit) ? runLen + 3'd1 : 3'd1;
    end
endmodule

// File: rtl/can_hdr_tx.sv
// can_hdr_tx: serializes SOF..DLC with bit stuffing; CAN_HDR_TX_STUFF_ERR_EN enables stuff-error injection
module can_hdr_tx
  import can_pkg::*;
(
  input logic clk,
  input logic resetN,
  can_hdr_tx_if.slave bus
);
  canHdrTx_t state, stateNext;
  logic [HDR_LEN-1:0] hdrR;
  logic [4:0] hdrIdx;
  logic load, step, drive, txBit, lastBit, stuffDue, errNow, hdrDone, capture;
  assign hdrDone = hdrIdx == 5'(HDR_LEN);
  assign capture = state == s_idle && bus.enable;
  assign drive = load || step;
`ifdef CAN_HDR_TX_STUFF_ERR_EN
  logic errArmed;
  assign errNow = errArmed;
  always_ff @(posedge clk)
    if (!resetN) errArmed <= 1'b0;
    else if (capture) errArmed <= bus.injectStuffErr;
    else if (state == s_stuff && drive) errArmed <= 1'b0;
`else
  assign errNow = 1'b0;
`endif
  assign txBit = state == s_stuff ? (errNow ? lastBit : ~lastBit) : hdrR[HDR_LEN-1];
  stuff_gen u_stuff (
    .clk(clk),
    .resetN(resetN),
    .load(load),
    .step(step),
    .bitIn(txBit),
    .lastBit(lastBit),
    .stuffDue(stuffDue)
  );
  always_ff @(posedge clk)
    if (!resetN) state <= s_idle;
    else state <= stateNext;
  // SOF and stuff bits restart the run; header bits extend it
  always_comb begin
    stateNext = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      s_idle: stateNext = bus.enable ? s_arm : s_idle;
      s_arm:
        if (!bus.enable) stateNext = s_idle;
        else if (bus.bitPulse) begin
          load = 1'b1;
          stateNext = s_hdr;
        end
      s_hdr:
        if (!bus.enable) stateNext = s_idle;
        else if (bus.bitPulse) begin
          step = !hdrDone;
          stateNext = hdrDone ? s_finish : stuffDue ? s_stuff : s_hdr;
        end
      s_stuff:
        if (!bus.enable) stateNext = s_idle;
        else if (bus.bitPulse) begin
          load = 1'b1;
          stateNext = hdrDone ? s_finish : s_hdr;
        end
      s_finish: stateNext = bus.enable ? s_finish : s_idle;
      default: stateNext = s_idle;
    endcase
  end
  // a trailing stuff bit is held until the next bit time, then the line goes recessive
  always_ff @(posedge clk)
    if (!resetN) begin
      hdrR <= '0;
      hdrIdx <= '0;
      bus.dOut <= 1'b1;
      bus.txActive <= 1'b0;
      bus.completeTx <= 1'b0;
      bus.stuffCount <= '0;
      bus.bitCount <= '0;
    end else begin
      if (capture) begin
        hdrR <= {1'b0, bus.canId, bus.rtr, 2'b00, bus.dlc};
        hdrIdx <= '0;
        bus.bitCount <= '0;
        bus.stuffCount <= '0;
        bus.txActive <= 1'b1;
        bus.completeTx <= 1'b0;
      end
      if (drive) begin
        bus.dOut <= txBit;
        bus.bitCount <= bus.bitCount + 5'(bus.bitCount != 5'd31);
      end
      if (drive && state != s_stuff) begin
        hdrR <= hdrR << 1;
        hdrIdx <= hdrIdx + 5'd1;
      end
      if (drive && state == s_stuff) bus.stuffCount <= bus.stuffCount + 3'(bus.stuffCount != 3'd7);
      if (state == s_finish && bus.bitPulse) bus.dOut <= 1'b1;
      if (stateNext == s_finish && state != s_finish) begin
        bus.completeTx <= 1'b1;
        bus.txActive <= 1'b0;
        if (state == s_hdr) bus.dOut <= 1'b1;
      end
      if (stateNext == s_idle && state != s_idle) begin
        bus.dOut <= 1'b1;
        bus.txActive <= 1'b0;
        bus.completeTx <= 1'b0;
      end
    end
endmodule

// File: tb/tb_can_hdr_tx.sv
// tb_can_hdr_tx: scoreboard bench for the CAN header transmitter
module tb_can_hdr_tx;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int checks = 0;
  int errors = 0;
  bit expQ[$];
  bit trailing;
  int nStuff;
  can_hdr_tx_if bus ();
  can_hdr_tx dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic build(input logic [10:0] id, input logic r, input logic [3:0] d, input bit inj);
    logic [18:0] hdr;
    bit last, sb, used;
    int run;
    hdr = {1'b0, id, r, 2'b00, d};
    nStuff = 0;
    trailing = 0;
    used = 0;
    last = 0;
    run = 0;
    for (int i = 0; i < 19; i++) begin
      bit b;
      b = hdr[18-i];
      expQ.push_back(b);
      trailing = 0;
      run = (i == 0 || b != last) ? 1 : run + 1;
      last = b;
      if (run == 5) begin
        sb = (inj && !used) ? last : ~last;
        used = used | inj;
        expQ.push_back(sb);
        last = sb;
        run = 1;
        nStuff++;
        trailing = 1;
      end
    end
  endtask

  task automatic pulse();
    @(negedge clk) bus.bitPulse = 1'b1;
    @(negedge clk) bus.bitPulse = 1'b0;
  endtask

  task automatic start(input logic [10:0] id, input logic r, input logic [3:0] d, input bit inj);
    @(negedge clk);
    bus.enable = 1'b1;
    bus.canId = id;
    bus.rtr = r;
    bus.dlc = d;
`ifdef CAN_HDR_TX_STUFF_ERR_EN
    bus.injectStuffErr = inj;
`endif
    @(negedge clk);
    bus.canId = ~id;
    bus.rtr = ~r;
    bus.dlc = ~d;
`ifdef CAN_HDR_TX_STUFF_ERR_EN
    bus.injectStuffErr = ~inj;
`endif
    checks++;
    if (bus.txActive !== 1'b1) begin
      errors++;
      $display("FAIL armed_txActive: got %0b want 1", bus.txActive);
    end
    checks++;
    if (bus.dOut !== 1'b1) begin
      errors++;
      $display("FAIL armed_dOut: got %0b want 1", bus.dOut);
    end
  endtask

  task automatic send_bits(input int n);
    bit e, prev;
    prev = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k % 3 != 0) begin
        repeat (k % 3) @(negedge clk);
        checks++;
        if (bus.dOut !== prev) begin
          errors++;
          $display("FAIL hold bit %0d: dOut got %0b want %0b", k - 1, bus.dOut, prev);
        end
      end
      pulse();
      e = expQ.pop_front();
      checks++;
      if (bus.dOut !== e) begin
        errors++;
        $display("FAIL bit %0d: dOut got %0b want %0b", k, bus.dOut, e);
      end
      prev = e;
    end
  endtask

  task automatic test_frame(input logic [10:0] id, input logic r, input logic [3:0] d, input bit inj,
                            input int expBits, input int expStuff);
    build(id, r, d, inj);
    start(id, r, d, inj);
    send_bits(expQ.size());
    if (!trailing) begin
      checks++;
      if (bus.completeTx !== 1'b0) begin
        errors++;
        $display("FAIL early_complete id=%h: got %0b want 0", id, bus.completeTx);
      end
      pulse();
      checks++;
      if (bus.dOut !== 1'b1) begin
        errors++;
        $display("FAIL finish_dOut id=%h: got %0b want 1", id, bus.dOut);
      end
    end
    checks++;
    if (bus.completeTx !== 1'b1) begin
      errors++;
      $display("FAIL complete id=%h: got %0b want 1", id, bus.completeTx);
    end
    checks++;
    if (bus.txActive !== 1'b0) begin
      errors++;
      $display("FAIL done_txActive id=%h: got %0b want 0", id, bus.txActive);
    end
    checks++;
    if (bus.bitCount !== 5'(expBits)) begin
      errors++;
      $display("FAIL bitCount id=%h: got %0d want %0d", id, bus.bitCount, expBits);
    end
    checks++;
    if (bus.stuffCount !== 3'(expStuff)) begin
      errors++;
      $display("FAIL stuffCount id=%h: got %0d want %0d", id, bus.stuffCount, expStuff);
    end
    checks++;
    if (nStuff != expStuff) begin
      errors++;
      $display("FAIL model_stuffs id=%h: got %0d want %0d", id, nStuff, expStuff);
    end
    pulse();
    checks++;
    if (bus.bitCount !== 5'(expBits) || bus.completeTx !== 1'b1) begin
      errors++;
      $display("FAIL finish_ignore id=%h: bitCount %0d completeTx %0b want %0d 1", id, bus.bitCount,
               bus.completeTx, expBits);
    end
    @(negedge clk) bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.completeTx !== 1'b0 || bus.dOut !== 1'b1) begin
      errors++;
      $display("FAIL release id=%h: completeTx %0b dOut %0b want 0 1", id, bus.completeTx, bus.dOut);
    end
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    bus.bitPulse = 1'b0;
    bus.canId = '0;
    bus.rtr = 1'b0;
    bus.dlc = '0;
`ifdef CAN_HDR_TX_STUFF_ERR_EN
    bus.injectStuffErr = 1'b0;
`endif
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.dOut, bus.txActive, bus.completeTx, bus.stuffCount, bus.bitCount} !== {3'b100, 3'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset: dOut %0b txActive %0b completeTx %0b stuff %0d bits %0d want 1 0 0 0 0",
               bus.dOut, bus.txActive, bus.completeTx, bus.stuffCount, bus.bitCount);
    end
    resetN = 1'b1;
  endtask

  task automatic test_abort();
    build(11'h103, 1'b0, 4'h3, 1'b0);
    start(11'h103, 1'b0, 4'h3, 1'b0);
    send_bits(7);
    @(negedge clk) bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.dOut, bus.txActive, bus.completeTx} !== 3'b100) begin
      errors++;
      $display("FAIL abort: dOut %0b txActive %0b completeTx %0b want 1 0 0", bus.dOut, bus.txActive,
               bus.completeTx);
    end
    checks++;
    if (bus.bitCount !== 5'd7) begin
      errors++;
      $display("FAIL abort_hold: bitCount got %0d want 7", bus.bitCount);
    end
    repeat (4) pulse();
    checks++;
    if (bus.completeTx !== 1'b0 || bus.bitCount !== 5'd7) begin
      errors++;
      $display("FAIL idle_ignore: completeTx %0b bitCount %0d want 0 7", bus.completeTx, bus.bitCount);
    end
    expQ.delete();
    build(11'h103, 1'b0, 4'h3, 1'b0);
    start(11'h103, 1'b0, 4'h3, 1'b0);
    send_bits(3);
    @(negedge clk) begin
      bus.enable = 1'b0;
      bus.bitPulse = 1'b1;
    end
    @(negedge clk) bus.bitPulse = 1'b0;
    checks++;
    if (bus.bitCount !== 5'd3 || bus.dOut !== 1'b1) begin
      errors++;
      $display("FAIL abort_wins: bitCount %0d dOut %0b want 3 1", bus.bitCount, bus.dOut);
    end
    expQ.delete();
  endtask

  task automatic test_reset_mid();
    build(11'h555, 1'b0, 4'h8, 1'b0);
    start(11'h555, 1'b0, 4'h8, 1'b0);
    send_bits(3);
    @(negedge clk) begin
      resetN = 1'b0;
      bus.enable = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({bus.dOut, bus.txActive, bus.completeTx, bus.stuffCount, bus.bitCount} !== {3'b100, 3'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_mid: dOut %0b txActive %0b completeTx %0b stuff %0d bits %0d want 1 0 0 0 0",
               bus.dOut, bus.txActive, bus.completeTx, bus.stuffCount, bus.bitCount);
    end
    resetN = 1'b1;
    expQ.delete();
  endtask

  initial begin
    test_reset();
    test_frame(11'h000, 1'b0, 4'h0, 1'b0, 22, 3);
    test_frame(11'h7FF, 1'b1, 4'hF, 1'b0, 21, 2);
    test_frame(11'h555, 1'b0, 4'h8, 1'b0, 19, 0);
    test_frame(11'h100, 1'b0, 4'h0, 1'b0, 22, 3);
    test_abort();
    test_frame(11'h555, 1'b0, 4'h8, 1'b0, 19, 0);
    test_reset_mid();
    test_frame(11'h7FF, 1'b1, 4'hF, 1'b0, 21, 2);
`ifdef CAN_HDR_TX_STUFF_ERR_EN
    test_frame(11'h000, 1'b0, 4'h0, 1'b1, 23, 4);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
